// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-path constants and the {pc, instr} entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Widths of the reference 64-bit core; the entry type below uses them.
  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned ILEN_DEF = 32;

  // addi x0,x0,0 - presented to decode whenever the queue is empty.
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  // Sequential fetch step in bytes.
  localparam int unsigned PC_INCR = 4;

  // One buffered fetch: the address and the word found there.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit_if
// Description : Instruction-memory, decode handshake, redirect and status
//               signals of the fetch queue. master = fetch unit side,
//               slave = surrounding core / memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
);

  logic [XLEN-1:0]              imem_addr;
  logic [ILEN-1:0]              imem_instr;
  logic                         id_valid;
  logic                         id_ready;
  logic [ILEN-1:0]              id_instr;
  logic [XLEN-1:0]              id_pc;
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic [15:0]                  flush_count;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, occupancy, flush_count,
    input  imem_instr, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, occupancy, flush_count,
    output imem_instr, id_ready, redirect_valid, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with push/pop/flush, explicit occupancy
//               counter and registered head outputs. Push is refused when
//               full even if a pop happens in the same cycle (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         push_i,
  input  wire logic [WIDTH-1:0]             push_data_i,
  input  wire logic                         pop_i,
  input  wire logic                         flush_i,
  output logic                              head_valid_o,
  output logic [WIDTH-1:0]                  head_data_o,
  output logic                              full_o,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rptr_q];
  assign occupancy_o  = count_q;
  assign push_ok      = push_i && !full_o && !flush_i;
  assign pop_ok       = pop_i && head_valid_o && !flush_i;

  // Pointer and occupancy next-state; flush empties the queue outright.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, cleared on reset so the head never shows X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : IF stage owning the PC, fetching from combinational imem into
//               a DEPTH-entry {pc, instr} queue drained by decode through a
//               valid/ready handshake. A redirect flushes the queue and
//               reloads the PC in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import riscv_pkg::*;
#(
  parameter int unsigned            XLEN      = 64,
  parameter int unsigned            ILEN      = 32,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [XLEN-1:0]        RESET_PC  = '0,
  parameter logic [ILEN-1:0]        NOP_INSTR = ILEN'(NOP_INSTR_C)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  fetch_queue_unit_if.master   bus
);

  localparam int unsigned ENTRY_W = XLEN + ILEN;

  logic [XLEN-1:0]            pc_q, pc_d;
  logic [15:0]                flush_count_q, flush_count_d;
  logic                       enq;
  logic                       deq;
  logic                       head_valid;
  logic [ENTRY_W-1:0]         head_data;
  logic                       fifo_full;
  logic [$clog2(DEPTH+1)-1:0] occ;

  // Redirect blocks both sides of the queue in its cycle; a full queue
  // refuses fetch even when decode drains an entry in the same cycle.
  assign enq = !bus.redirect_valid && !fifo_full;
  assign deq = head_valid && bus.id_ready && !bus.redirect_valid;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (enq),
    .push_data_i  ({pc_q, bus.imem_instr}),
    .pop_i        (deq),
    .flush_i      (bus.redirect_valid),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .full_o       (fifo_full),
    .occupancy_o  (occ)
  );

  // PC and redirect-counter next-state: redirect wins, else advance on fetch.
  always_comb begin
    pc_d          = pc_q;
    flush_count_d = flush_count_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      if (flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end else if (enq) begin
      pc_d = pc_q + XLEN'(PC_INCR);
    end
  end

  // PC and redirect-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      flush_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Decode-facing outputs come from queue head storage only.
  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = head_valid;
  assign bus.id_pc       = head_valid ? head_data[ENTRY_W-1:ILEN] : '0;
  assign bus.id_instr    = head_valid ? head_data[ILEN-1:0] : NOP_INSTR;
  assign bus.occupancy   = occ;
  assign bus.flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit: directed vector
//               table, randomized run against a queue-based reference model,
//               and a flush_count saturation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] ONES_M3 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        reset;
  logic [31:0] salt;
  int          checks;
  int          failures;

  fetch_queue_unit_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(
    .XLEN      (XLEN),
    .ILEN      (ILEN),
    .DEPTH     (DEPTH),
    .RESET_PC  (64'h0),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word depends only on the address and a salt.
  always_comb bus.imem_instr = bus.imem_addr[31:0] ^ salt;

  // Reference model state.
  fetch_entry_t m_q[$];
  logic [63:0]  m_pc;
  logic [15:0]  m_fc;

  typedef struct {
    bit          rst;
    bit          rv;
    logic [63:0] rpc;
    bit          rdy;
    bit          e_valid;
    logic [63:0] e_pc;
    int          e_occ;
    logic [63:0] e_addr;
    int          e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit rv, logic [63:0] rpc, bit rdy,
                              bit ev, logic [63:0] epc, int eocc,
                              logic [63:0] eaddr, int efc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_occ = eocc; v.e_addr = eaddr; v.e_fc = efc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the spec's rules.
  task automatic model_edge(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
    bit can_enq;
    fetch_entry_t e;
    if (rst) begin
      m_pc = 64'h0;
      m_q.delete();
      m_fc = 16'h0;
    end else if (rv) begin
      m_pc = rpc;
      m_q.delete();
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end else begin
      can_enq = (m_q.size() < DEPTH);
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (can_enq) begin
        e.pc    = m_pc;
        e.instr = m_pc[31:0] ^ salt;
        m_q.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic model_check(input bit full_check);
    bit          v;
    logic [63:0] epc;
    logic [31:0] ein;
    v   = (m_q.size() > 0);
    epc = v ? m_q[0].pc : 64'h0;
    ein = v ? m_q[0].instr : 32'h0000_0013;
    chk("m_flush_count", 64'(bus.flush_count), 64'(m_fc));
    if (full_check) begin
      chk("m_imem_addr", bus.imem_addr, m_pc);
      chk("m_id_valid", 64'(bus.id_valid), 64'(v));
      chk("m_id_pc", bus.id_pc, epc);
      chk("m_id_instr", 64'(bus.id_instr), 64'(ein));
      chk("m_occupancy", 64'(bus.occupancy), 64'(m_q.size()));
    end
  endtask

  // Drive inputs, take one edge, then sample 1ns later.
  task automatic step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy,
                      input bit full_check);
    reset              = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    @(posedge clk);
    model_edge(rst, rv, rpc, rdy);
    #1;
    model_check(full_check);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    salt               = 32'h0;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = 1'b0;
    m_pc               = 64'h0;
    m_fc               = 16'h0;

    // Directed table: imem word == address, so id_instr must equal id_pc.
    //              rst rv rpc           rdy  valid pc         occ addr        fc
    vecs.push_back(mk(1, 0, 64'h0,        1,   0, 64'h0,      0, 64'h0,       0));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h0,      1, 64'h4,       0));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h4,      1, 64'h8,       0));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h8,      1, 64'hC,       0));
    vecs.push_back(mk(1, 0, 64'h0,        0,   0, 64'h0,      0, 64'h0,       0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h0,      1, 64'h4,       0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h0,      2, 64'h8,       0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h0,      3, 64'hC,       0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h0,      4, 64'h10,      0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h0,      4, 64'h10,      0));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h4,      3, 64'h10,      0));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h4,      4, 64'h14,      0));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h8,      3, 64'h14,      0));
    vecs.push_back(mk(0, 1, 64'h200,      1,   0, 64'h0,      0, 64'h200,     1));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h200,    1, 64'h204,     1));
    vecs.push_back(mk(0, 1, 64'h100,      1,   0, 64'h0,      0, 64'h100,     2));
    vecs.push_back(mk(0, 1, 64'h300,      1,   0, 64'h0,      0, 64'h300,     3));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, 64'h300,    1, 64'h304,     3));
    vecs.push_back(mk(0, 1, ONES_M3,      0,   0, 64'h0,      0, ONES_M3,     4));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, ONES_M3,    1, 64'h0,       4));
    vecs.push_back(mk(0, 0, 64'h0,        0,   1, ONES_M3,    2, 64'h4,       4));
    vecs.push_back(mk(0, 0, 64'h0,        1,   1, 64'h0,      2, 64'h8,       4));
    vecs.push_back(mk(1, 1, 64'h500,      1,   0, 64'h0,      0, 64'h0,       0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, 1'b1);
      chk("v_id_valid", 64'(bus.id_valid), 64'(vecs[i].e_valid));
      chk("v_id_pc", bus.id_pc, vecs[i].e_pc);
      chk("v_id_instr", 64'(bus.id_instr),
          vecs[i].e_valid ? 64'(vecs[i].e_pc[31:0]) : 64'h13);
      chk("v_occupancy", 64'(bus.occupancy), 64'(vecs[i].e_occ));
      chk("v_imem_addr", bus.imem_addr, vecs[i].e_addr);
      chk("v_flush_count", 64'(bus.flush_count), 64'(vecs[i].e_fc));
    end

    // Randomized run against the reference model.
    salt = $urandom;
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = ONES_M3 - 64'(4 * $urandom_range(0, 3));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rpc,
           $urandom_range(0, 2) != 0, 1'b1);
    end

    // flush_count saturation: back-to-back redirects past 16'hFFFF.
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int n = 0; n < 65540; n++) begin
      step(1'b0, 1'b1, 64'(n) << 2, 1'b1, (n > 65530));
    end
    chk("sat_flush_count", 64'(bus.flush_count), 64'hFFFF);
    step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("sat_hold", 64'(bus.flush_count), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-register IF stage of the 5-stage RISC-V core.
- Owns the PC and fetches from the combinational instruction memory.
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO, so decode stalls no longer freeze fetch.
- Supports a single-cycle redirect (taken branch/jump) that flushes all buffered wrong-path instructions.
- Sits between instruction_memory and the IF/ID boundary; the decode stage consumes through a valid/ready handshake.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, DEPTH >= 2.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction presented when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  XLEN  fetch address, equal to current PC.
- imem_instr  in  ILEN  instruction at imem_addr, combinationally valid in the same cycle.
- id_valid  out  1  head entry valid.
- id_ready  in  1  decode accepts head (low = stall).
- id_instr  out  ILEN  head instruction; NOP_INSTR when id_valid=0.
- id_pc  out  XLEN  head PC; 0 when id_valid=0.
- redirect_valid  in  1  branch/jump resolved taken.
- redirect_pc  in  XLEN  redirect target.
- occupancy  out  $clog2(DEPTH+1)  entries currently buffered.
- flush_count  out  16  number of redirects taken since reset; saturates at 16'hFFFF.

Behaviour:
- Reset values: PC=RESET_PC, FIFO empty, occupancy=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, flush_count=0. Reset overrides redirect and all other inputs.
- imem_addr = PC, combinational from the PC register.
- Enqueue (enq): !redirect_valid && occupancy < DEPTH.
  - On enq, write {PC, imem_instr} at the tail and set PC <= PC + 4, with XLEN wrap-around (all-ones - 3 wraps to 0).
  - No full-bypass: when occupancy==DEPTH, enq does not occur even if a dequeue happens in the same cycle. PC holds.
- Dequeue (deq): id_valid && id_ready && !redirect_valid. The head pointer advances.
- Simultaneous enq and deq: occupancy is unchanged and both pointers advance.
- Latency: an instruction fetched in cycle N is visible at id_* in cycle N+1 at the earliest. There is no empty-queue bypass.
- Outputs id_valid, id_instr and id_pc are driven from FIFO head storage, not from imem.
- Redirect (highest priority after reset):
  - next cycle: PC=redirect_pc, occupancy=0, pointers=0, id_valid=0;
  - no enq and no deq in the redirect cycle; the head is not consumed even if id_ready=1;
  - flush_count increments by 1, saturating.
  - Back-to-back redirects are each honoured; the last one wins.
- Pointers: log2(DEPTH) bits, wrap naturally. occupancy is maintained as a separate counter, so full and empty are unambiguous.
- Stall: with id_ready=0 held, the FIFO fills to DEPTH and then PC holds. The head stays stable until accepted.
- Misaligned redirect_pc is accepted as-is; alignment checking is out of scope.
- No X propagation: FIFO storage is cleared on reset.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, the fetch-entry struct/typedef {pc, instr}, and the PC increment constant 4.
- One sub-module, fetch_fifo: parametrised synchronous FIFO with push, pop, flush, occupancy and head outputs, reusable for a future decode queue.
- Top level holds the PC register, the enq/deq/redirect control and flush_count.

Test Plan:
- Reset release, imem returns word = addr, id_ready=1: imem_addr goes 0,4,8,…; id_valid rises 1 cycle after reset deassert; id_pc/id_instr = 0/0, then 4/4, …; occupancy stays 1.
- id_ready=0 from reset: occupancy counts 1..4 and stays at 4; imem_addr freezes at 0x10; id_pc holds 0.
- Full queue, then id_ready=1 for one cycle: that cycle dequeues pc 0 with no enq; next cycle enqueues 0x10; occupancy goes 4 → 3 → 4.
- Occupancy 3, id_ready=1, redirect_valid=1 with redirect_pc=0x200: next cycle id_valid=0, occupancy=0, imem_addr=0x200, flush_count=1; the head was not consumed; the following cycle id_pc=0x200.
- Redirect in two consecutive cycles (0x100, then 0x300): the final PC is 0x300 and flush_count=2.
- Redirect to XLEN all-ones minus 3, then 2 fetches: id_pc is all-ones minus 3, then 0 (wrap); reset asserted mid-stream restores PC=RESET_PC and occupancy=0 on the next edge.
